// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lsu_pkg : FSM state codes, access size codes and size helpers for LSU  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] MEM_SZ_B = 2'd0;
  localparam logic [1:0] MEM_SZ_H = 2'd1;
  localparam logic [1:0] MEM_SZ_W = 2'd2;

  // The reserved code 3 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'd3) ? MEM_SZ_W : sz;
  endfunction

  function automatic logic [1:0] size_mask(input logic [1:0] sz);
    logic [1:0] n;
    n = norm_size(sz);
    return (n == MEM_SZ_B) ? 2'b00 : (n == MEM_SZ_H) ? 2'b01 : 2'b11;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_extend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lsu_extend : load lane select and sign/zero extension (combinational)  |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module mem_lsu_extend
  import mem_lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    shifted  = data_i >> {off_i, 3'b000};
    sext     = 1'b0;
    result_o = shifted;
    case (norm_size(size_i))
      MEM_SZ_B: begin
        sext     = shifted[7] & ~unsigned_i;
        result_o = {{24{sext}}, shifted[7:0]};
      end
      MEM_SZ_H: begin
        sext     = shifted[15] & ~unsigned_i;
        result_o = {{16{sext}}, shifted[15:0]};
      end
      default: result_o = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lsu : MEM-stage load/store unit with req/gnt/rvalid RAM handshake and  |
// |           beat splitting. Optional macro MEM_MISALIGN_TRAP_EN traps        |
// |           misaligned accesses instead of aligning them.                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int BUS_BYTES = 1,
  parameter int RA_W      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [1:0]             size_i,
  input  logic                   unsigned_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [RA_W-1:0]        wd_i,
  input  logic                   wreg_i,
  input  logic [XLEN-1:0]        wdata_i,
  output logic [RA_W-1:0]        wd_o,
  output logic                   wreg_o,
  output logic [XLEN-1:0]        wdata_o,
  output logic                   stall_req_o,
  output logic                   ram_req_o,
  output logic                   ram_we_o,
  output logic [ADDR_W-1:0]      ram_addr_o,
  output logic [BUS_BYTES-1:0]   ram_be_o,
  output logic [8*BUS_BYTES-1:0] ram_wdata_o,
  input  logic                   ram_gnt_i,
  input  logic                   ram_rvalid_i,
  input  logic [8*BUS_BYTES-1:0] ram_rdata_i,
  output logic                   fault_o
);

  localparam int         BEAT_W   = $clog2(4 / BUS_BYTES) + 1;
  localparam logic [1:0] OFF_MASK = 2'(BUS_BYTES - 1);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic [XLEN-1:0]   lbuf_q, lbuf_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic              misaligned;
  logic              multi;
  logic              last_beat;
  logic [1:0]        lane_off;
  int                acc_bytes;
  logic [XLEN-1:0]   load_res;
  logic [ADDR_W-1:0] beat_addr;
  logic [BUS_BYTES-1:0]   beat_be;
  logic [8*BUS_BYTES-1:0] beat_wdata;

`ifdef MEM_MISALIGN_TRAP_EN
  logic fault_q;

  always_comb begin
    misaligned = (addr_i[1:0] & size_mask(size_i)) != 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= (state_q == LSU_IDLE) && req_i && misaligned;
  end

  assign fault_o = (state_q == LSU_DONE) && fault_q;
`else
  assign misaligned = 1'b0;
  assign fault_o    = 1'b0;
`endif

  // Beat geometry derived from the latched access.
  always_comb begin
    acc_bytes = 1 << int'(size_q);
    multi     = acc_bytes > BUS_BYTES;
    last_beat = ((int'(beat_q) + 1) * BUS_BYTES) >= acc_bytes;
    lane_off  = multi ? 2'b00 : (addr_q[1:0] & OFF_MASK);
    beat_addr = (addr_q & ~ADDR_W'(BUS_BYTES - 1)) + ADDR_W'(int'(beat_q) * BUS_BYTES);
  end

  // Narrow accesses replicate the store data across lanes; wide ones slice it low byte first.
  always_comb begin
    beat_be    = '0;
    beat_wdata = '0;
    for (int j = 0; j < BUS_BYTES; j++) begin
      beat_be[j] = multi || ((j >= int'(lane_off)) && (j < int'(lane_off) + acc_bytes));
      if (multi) beat_wdata[8*j +: 8] = sdata_q[8*(int'(beat_q)*BUS_BYTES + j) +: 8];
      else       beat_wdata[8*j +: 8] = sdata_q[8*(j & (acc_bytes - 1)) +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    lbuf_d  = lbuf_q;
    beat_d  = beat_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          size_d  = norm_size(size_i);
          uns_d   = unsigned_i;
          addr_d  = {addr_i[ADDR_W-1:2], addr_i[1:0] & ~size_mask(size_i)};
          sdata_d = wdata_i;
          lbuf_d  = '0;
          beat_d  = '0;
          state_d = misaligned ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (ram_gnt_i) begin
          if (!we_q) begin
            state_d = LSU_WAIT;
          end else if (last_beat) begin
            state_d = LSU_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      LSU_WAIT: begin
        if (ram_rvalid_i) begin
          for (int j = 0; j < BUS_BYTES; j++) begin
            if ((int'(beat_q) * BUS_BYTES + j) < XLEN / 8)
              lbuf_d[8*(int'(beat_q)*BUS_BYTES + j) +: 8] = ram_rdata_i[8*j +: 8];
          end
          if (last_beat) begin
            state_d = LSU_DONE;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = LSU_REQ;
          end
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      lbuf_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      lbuf_q  <= lbuf_d;
      beat_q  <= beat_d;
    end
  end

  mem_lsu_extend u_extend (
    .data_i     (lbuf_q),
    .off_i      (lane_off),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (load_res)
  );

  assign stall_req_o = req_i && (state_q != LSU_DONE);
  assign ram_req_o   = (state_q == LSU_REQ);
  assign ram_we_o    = ram_req_o && we_q;
  assign ram_addr_o  = ram_req_o ? beat_addr  : '0;
  assign ram_be_o    = ram_req_o ? beat_be    : '0;
  assign ram_wdata_o = (ram_req_o && we_q) ? beat_wdata : '0;

  always_comb begin
    wd_o    = wd_i;
    wreg_o  = wreg_i;
    wdata_o = wdata_i;
    if (req_i && (state_q == LSU_DONE) && !we_q) wdata_o = load_res;
`ifdef MEM_MISALIGN_TRAP_EN
    if (fault_o) wreg_o = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_lsu : directed bench for mem_lsu on a 4-byte and a 1-byte RAM bus    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, uns, wreg;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [4:0]  wd;

  logic        req4, stall4, rreq4, rwe4, gnt4, rvalid4, fault4, wreg4_o;
  logic [31:0] raddr4, rwdata4, rdata4, wdata4_o;
  logic [3:0]  rbe4;
  logic [4:0]  wd4_o;

  logic        req1, stall1, rreq1, rwe1, gnt1, rvalid1, fault1, wreg1_o;
  logic [31:0] raddr1, wdata1_o;
  logic [7:0]  rwdata1, rdata1;
  logic [0:0]  rbe1;
  logic [4:0]  wd1_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_lsu #(.XLEN(32), .ADDR_W(32), .BUS_BYTES(4), .RA_W(5)) u_dut4 (
    .clk(clk), .rst(rst), .req_i(req4), .we_i(we), .size_i(size), .unsigned_i(uns),
    .addr_i(addr), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata),
    .wd_o(wd4_o), .wreg_o(wreg4_o), .wdata_o(wdata4_o), .stall_req_o(stall4),
    .ram_req_o(rreq4), .ram_we_o(rwe4), .ram_addr_o(raddr4), .ram_be_o(rbe4),
    .ram_wdata_o(rwdata4), .ram_gnt_i(gnt4), .ram_rvalid_i(rvalid4),
    .ram_rdata_i(rdata4), .fault_o(fault4)
  );

  mem_lsu #(.XLEN(32), .ADDR_W(32), .BUS_BYTES(1), .RA_W(5)) u_dut1 (
    .clk(clk), .rst(rst), .req_i(req1), .we_i(we), .size_i(size), .unsigned_i(uns),
    .addr_i(addr), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata),
    .wd_o(wd1_o), .wreg_o(wreg1_o), .wdata_o(wdata1_o), .stall_req_o(stall1),
    .ram_req_o(rreq1), .ram_we_o(rwe1), .ram_addr_o(raddr1), .ram_be_o(rbe1),
    .ram_wdata_o(rwdata1), .ram_gnt_i(gnt1), .ram_rvalid_i(rvalid1),
    .ram_rdata_i(rdata1), .fault_o(fault1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One BUS_BYTES=4 load with immediate grant and rvalid one cycle later.
  task automatic load4(input string tag, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] rd,
                       input logic [31:0] exp_res);
    req4 = 1'b1; we = 1'b0; size = sz; uns = u; addr = a;
    wd = 5'd9; wreg = 1'b1; wdata = 32'h5555_AAAA; gnt4 = 1'b1; rvalid4 = 1'b0;
    #1 chk({tag, ".stall_idle"}, stall4, 1);
    tick();
    chk({tag, ".req"}, rreq4, 1);
    chk({tag, ".we"}, rwe4, 0);
    chk({tag, ".addr"}, raddr4, exp_addr);
    chk({tag, ".be"}, rbe4, exp_be);
    chk({tag, ".stall_req"}, stall4, 1);
    tick();
    gnt4 = 1'b0; rvalid4 = 1'b1; rdata4 = rd;
    #1 chk({tag, ".stall_wait"}, stall4, 1);
    chk({tag, ".req_wait"}, rreq4, 0);
    tick();
    rvalid4 = 1'b0; rdata4 = '0;
    chk({tag, ".stall_done"}, stall4, 0);
    chk({tag, ".result"}, wdata4_o, exp_res);
    chk({tag, ".wd"}, wd4_o, 9);
    chk({tag, ".wreg"}, wreg4_o, 1);
    req4 = 1'b0;
    tick();
  endtask

  // One BUS_BYTES=4 store; grant withheld for gdelay cycles.
  task automatic store4(input string tag, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd, input int gdelay);
    req4 = 1'b1; we = 1'b1; size = sz; uns = 1'b0; addr = a;
    wd = 5'd0; wreg = 1'b0; wdata = d; gnt4 = 1'b0; rvalid4 = 1'b0;
    #1 chk({tag, ".stall_idle"}, stall4, 1);
    tick();
    for (int i = 0; i <= gdelay; i++) begin
      if (i == gdelay) gnt4 = 1'b1;
      #1;
      chk({tag, ".req"}, rreq4, 1);
      chk({tag, ".we"}, rwe4, 1);
      chk({tag, ".addr"}, raddr4, exp_addr);
      chk({tag, ".be"}, rbe4, exp_be);
      chk({tag, ".wdata"}, rwdata4, exp_wd);
      chk({tag, ".stall_req"}, stall4, 1);
      tick();
    end
    gnt4 = 1'b0;
    chk({tag, ".stall_done"}, stall4, 0);
    chk({tag, ".req_done"}, rreq4, 0);
    req4 = 1'b0;
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req4 = 1'b0; req1 = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0;
    addr = '0; wd = '0; wreg = 1'b0; wdata = '0;
    gnt4 = 1'b0; rvalid4 = 1'b0; rdata4 = '0;
    gnt1 = 1'b0; rvalid1 = 1'b0; rdata1 = '0;
    tick();
    tick();
    chk("rst.req", rreq4, 0);
    chk("rst.we", rwe4, 0);
    chk("rst.addr", raddr4, 0);
    chk("rst.be", rbe4, 0);
    chk("rst.wdata", rwdata4, 0);
    chk("rst.fault", fault4, 0);
    chk("rst.req1", rreq1, 0);
    rst = 1'b0;

    // No memory op: pipeline fields pass straight through.
    wd = 5'd5; wreg = 1'b1; wdata = 32'hDEAD_BEEF;
    #1 chk("pass.wd", wd4_o, 5);
    chk("pass.wreg", wreg4_o, 1);
    chk("pass.wdata", wdata4_o, 32'hDEAD_BEEF);
    chk("pass.stall", stall4, 0);
    chk("pass.wdata1", wdata1_o, 32'hDEAD_BEEF);
    tick();

    load4("lw",  2'd2, 1'b0, 32'h100, 32'h100, 4'b1111, 32'h8000_00F0, 32'h8000_00F0);
    load4("lb",  2'd0, 1'b0, 32'h103, 32'h100, 4'b1000, 32'h80AB_CDEF, 32'hFFFF_FF80);
    load4("lbu", 2'd0, 1'b1, 32'h103, 32'h100, 4'b1000, 32'h80AB_CDEF, 32'h0000_0080);
    load4("lh",  2'd1, 1'b0, 32'h102, 32'h100, 4'b1100, 32'hBEEF_1234, 32'hFFFF_BEEF);
    load4("lhu", 2'd1, 1'b1, 32'h106, 32'h104, 4'b1100, 32'hBEEF_1234, 32'h0000_BEEF);
    load4("lw3", 2'd3, 1'b0, 32'h108, 32'h108, 4'b1111, 32'h0123_4567, 32'h0123_4567);

    store4("sb", 2'd0, 32'h101, 32'h0000_00AB, 32'h100, 4'b0010, 32'hABAB_ABAB, 0);
    store4("sh", 2'd1, 32'h102, 32'h0000_1234, 32'h100, 4'b1100, 32'h1234_1234, 0);
    store4("sw_gnt_late", 2'd2, 32'h204, 32'hCAFE_F00D, 32'h204, 4'b1111, 32'hCAFE_F00D, 5);

`ifdef MEM_MISALIGN_TRAP_EN
    req4 = 1'b1; we = 1'b0; size = 2'd1; uns = 1'b0; addr = 32'h101; wd = 5'd7; wreg = 1'b1;
    #1 chk("mis.stall_idle", stall4, 1);
    chk("mis.req_idle", rreq4, 0);
    tick();
    chk("mis.fault", fault4, 1);
    chk("mis.wreg", wreg4_o, 0);
    chk("mis.stall_done", stall4, 0);
    chk("mis.req_done", rreq4, 0);
    req4 = 1'b0;
    tick();
    chk("mis.fault_clear", fault4, 0);
`else
    load4("lh_mis", 2'd1, 1'b0, 32'h101, 32'h100, 4'b0011, 32'h1234_7FFE, 32'h0000_7FFE);
    chk("mis.fault_off", fault4, 0);
`endif

    // Reset while waiting for read data; the late rvalid must be ignored.
    req4 = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h140; gnt4 = 1'b1;
    tick();
    tick();
    gnt4 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; req4 = 1'b0;
    #1 chk("rstw.req", rreq4, 0);
    rvalid4 = 1'b1; rdata4 = 32'hFFFF_FFFF;
    tick();
    rvalid4 = 1'b0; rdata4 = '0; req4 = 1'b1; gnt4 = 1'b1;
    #1 chk("rstw.no_done", stall4, 1);
    chk("rstw.req_idle", rreq4, 0);
    tick();
    chk("rstw.req_again", rreq4, 1);
    chk("rstw.addr", raddr4, 32'h140);
    tick();
    gnt4 = 1'b0; rvalid4 = 1'b1; rdata4 = 32'h0BAD_F00D;
    tick();
    rvalid4 = 1'b0;
    chk("rstw.result", wdata4_o, 32'h0BAD_F00D);
    req4 = 1'b0;
    tick();

    // Byte-wide bus: a word store becomes four byte beats, low byte first.
    req1 = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h200; wdata = 32'h1122_3344; wreg = 1'b0;
    gnt1 = 1'b1;
    #1 chk("sw1.stall_idle", stall1, 1);
    tick();
    chk("sw1.b0.addr", raddr1, 32'h200); chk("sw1.b0.data", rwdata1, 8'h44);
    chk("sw1.b0.be", rbe1, 1); chk("sw1.b0.we", rwe1, 1);
    tick();
    chk("sw1.b1.addr", raddr1, 32'h201); chk("sw1.b1.data", rwdata1, 8'h33);
    chk("sw1.b1.be", rbe1, 1);
    tick();
    chk("sw1.b2.addr", raddr1, 32'h202); chk("sw1.b2.data", rwdata1, 8'h22);
    chk("sw1.b2.be", rbe1, 1);
    tick();
    chk("sw1.b3.addr", raddr1, 32'h203); chk("sw1.b3.data", rwdata1, 8'h11);
    chk("sw1.b3.be", rbe1, 1); chk("sw1.b3.stall", stall1, 1);
    tick();
    chk("sw1.stall_done", stall1, 0);
    chk("sw1.req_done", rreq1, 0);
    req1 = 1'b0; gnt1 = 1'b0;
    tick();

    // Byte-wide bus: signed halfword load assembled from two beats.
    req1 = 1'b1; we = 1'b0; size = 2'd1; uns = 1'b0; addr = 32'h300; wreg = 1'b1;
    wdata = 32'h0; gnt1 = 1'b1;
    tick();
    chk("lh1.b0.addr", raddr1, 32'h300);
    tick();
    gnt1 = 1'b0; rvalid1 = 1'b1; rdata1 = 8'h34;
    tick();
    rvalid1 = 1'b0; gnt1 = 1'b1;
    chk("lh1.b1.req", rreq1, 1);
    chk("lh1.b1.addr", raddr1, 32'h301);
    tick();
    gnt1 = 1'b0; rvalid1 = 1'b1; rdata1 = 8'h92;
    tick();
    rvalid1 = 1'b0;
    chk("lh1.stall_done", stall1, 0);
    chk("lh1.result", wdata1_o, 32'hFFFF_9234);
    req1 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
